// File: rtl/vdp_vram_host_write_queue_if.sv
// Host-write and arbiter host-slot signals of the VRAM host write queue.
// slave: the queue itself; master: the host register block plus arbiter side.
interface vdp_vram_host_write_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

    logic               host_address_load;
    logic [14:0]        host_address;
    logic               host_increment_load;
    logic [7:0]         host_increment;
    logic               host_write_valid;
    logic               host_write_ready;
    logic [15:0]        host_write_data;
    logic               vram_written;
    logic [13:0]        vram_write_address_16b;
    logic [15:0]        vram_write_data_16b;
    logic [1:0]         vram_port_write_en_mask;
    logic [LEVEL_W-1:0] queue_level;
    logic               queue_empty;

    modport slave (
        input  host_address_load,
        input  host_address,
        input  host_increment_load,
        input  host_increment,
        input  host_write_valid,
        output host_write_ready,
        input  host_write_data,
        input  vram_written,
        output vram_write_address_16b,
        output vram_write_data_16b,
        output vram_port_write_en_mask,
        output queue_level,
        output queue_empty
    );

    modport master (
        output host_address_load,
        output host_address,
        output host_increment_load,
        output host_increment,
        output host_write_valid,
        input  host_write_ready,
        output host_write_data,
        output vram_written,
        input  vram_write_address_16b,
        input  vram_write_data_16b,
        input  vram_port_write_en_mask,
        input  queue_level,
        input  queue_empty
    );
endinterface

// File: rtl/vdp_vram_host_write_queue.sv
// Host VRAM write FIFO feeding the arbiter host slot; owns the host address
// pointer with programmable auto-increment and even/odd bank selection.
module vdp_vram_host_write_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    vdp_vram_host_write_queue_if.slave     bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned INCR_W  = 8;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } entry_t;

    entry_t              mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [LEVEL_W-1:0]  level;
    logic [ADDR_W-1:0]   addr_ptr;
    logic [INCR_W-1:0]   incr;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t push_entry;
    entry_t head;

    assign full  = (level == LEVEL_W'(DEPTH));
    assign empty = (level == '0);
    assign push  = bus.host_write_valid && !full;
    assign pop   = bus.vram_written && !empty;

    assign push_entry.addr = addr_ptr[14:1];
    assign push_entry.data = bus.host_write_data;
    assign push_entry.mask = addr_ptr[0] ? 2'b10 : 2'b01;

    // Storage needs no reset: the level alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LEVEL_W'(1);
            end else if (pop && !push) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

    // Address pointer: explicit load beats auto-increment; a push in the
    // load cycle has already captured the old pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_ptr <= '0;
            incr     <= INCR_W'(1);
        end else begin
            if (bus.host_address_load) begin
                addr_ptr <= bus.host_address;
            end else if (push) begin
                addr_ptr <= addr_ptr + ADDR_W'(incr);
            end
            if (bus.host_increment_load) begin
                incr <= bus.host_increment;
            end
        end
    end

    assign head = mem[rd_ptr];

    assign bus.host_write_ready        = !full;
    assign bus.vram_write_address_16b  = head.addr;
    assign bus.vram_write_data_16b     = head.data;
    assign bus.vram_port_write_en_mask = empty ? 2'b00 : head.mask;
    assign bus.queue_level             = level;
    assign bus.queue_empty             = empty;

endmodule
